// File: rtl/inst_issue_buffer_pkg.sv
// Shared constants, entry layout and RV32I register-usage helpers for the
// instruction issue buffer.
package inst_issue_buffer_pkg;

  localparam int BUF_DEPTH = 8;
  localparam int PTR_W     = $clog2(BUF_DEPTH);
  localparam int CNT_W     = PTR_W + 1;

  localparam logic [6:0] OP_R     = 7'b0110011;
  localparam logic [6:0] OP_RI    = 7'b0010011;
  localparam logic [6:0] OP_LOAD  = 7'b0000011;
  localparam logic [6:0] OP_S     = 7'b0100011;
  localparam logic [6:0] OP_SB    = 7'b1100011;
  localparam logic [6:0] OP_JALR  = 7'b1100111;
  localparam logic [6:0] OP_JAL   = 7'b1101111;
  localparam logic [6:0] OP_AUIPC = 7'b0010111;
  localparam logic [6:0] OP_LUI   = 7'b0110111;

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] inst;
  } buf_entry_t;

  function automatic logic op_is_control(input logic [6:0] op);
    return (op == OP_SB) || (op == OP_JAL) || (op == OP_JALR);
  endfunction

  function automatic logic op_writes_rd(input logic [6:0] op);
    return (op == OP_R) || (op == OP_RI) || (op == OP_LOAD) || (op == OP_JALR) ||
           (op == OP_JAL) || (op == OP_AUIPC) || (op == OP_LUI);
  endfunction

  function automatic logic op_reads_rs1(input logic [6:0] op);
    return (op == OP_R) || (op == OP_RI) || (op == OP_LOAD) || (op == OP_S) ||
           (op == OP_SB) || (op == OP_JALR);
  endfunction

  function automatic logic op_reads_rs2(input logic [6:0] op);
    return (op == OP_R) || (op == OP_S) || (op == OP_SB);
  endfunction

endpackage

// File: rtl/inst_issue_buffer_pair_check.sv
// Decides whether the instruction behind slot 0 may issue alongside it:
// no pairing after control transfers or across a RAW dependency on rd.
module inst_pair_check
  import inst_issue_buffer_pkg::*;
(
  input  logic [31:0] i_slot0_inst,
  input  logic [31:0] i_slot1_inst,
  output logic        o_pair_ok
);

  logic [6:0] w_op0;
  logic [6:0] w_op1;
  logic [4:0] w_rd0;
  logic [4:0] w_rs1_1;
  logic [4:0] w_rs2_1;
  logic       w_ctrl0;
  logic       w_raw_rs1;
  logic       w_raw_rs2;
  logic       w_unused_fields;

  assign w_op0   = i_slot0_inst[6:0];
  assign w_rd0   = i_slot0_inst[11:7];
  assign w_op1   = i_slot1_inst[6:0];
  assign w_rs1_1 = i_slot1_inst[19:15];
  assign w_rs2_1 = i_slot1_inst[24:20];

  assign w_ctrl0 = op_is_control(w_op0);

  // x0 is hardwired, so a write to it never creates a dependency.
  assign w_raw_rs1 = op_writes_rd(w_op0) && (w_rd0 != 5'd0) &&
                     op_reads_rs1(w_op1) && (w_rs1_1 == w_rd0);
  assign w_raw_rs2 = op_writes_rd(w_op0) && (w_rd0 != 5'd0) &&
                     op_reads_rs2(w_op1) && (w_rs2_1 == w_rd0);

  assign o_pair_ok = !w_ctrl0 && !w_raw_rs1 && !w_raw_rs2;

  assign w_unused_fields = ^{i_slot0_inst[31:12], i_slot1_inst[31:25], i_slot1_inst[14:7]};

endmodule

// File: rtl/inst_issue_buffer.sv
// 8-entry circular instruction buffer between fetch and a dual-issue decode
// stage; accepts up to two instructions per cycle and presents up to two.
module inst_issue_buffer
  import inst_issue_buffer_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic        fetch_valid,
  input  logic        fetch_cnt,
  input  logic [31:0] fetch_pc,
  input  logic [31:0] fetch_inst0,
  input  logic [31:0] fetch_inst1,
  output logic        fetch_ready,
  output logic        issue_valid0,
  output logic        issue_valid1,
  output logic [31:0] issue_inst0,
  output logic [31:0] issue_inst1,
  output logic [31:0] issue_pc0,
  output logic [31:0] issue_pc1,
  input  logic [1:0]  issue_take,
  input  logic        flush,
  output logic [3:0]  occupancy
);

  localparam logic [CNT_W-1:0] READY_MAX = CNT_W'(BUF_DEPTH - 2);

  buf_entry_t       r_mem [BUF_DEPTH];
  logic [PTR_W-1:0] r_head;
  logic [PTR_W-1:0] r_tail;
  logic [CNT_W-1:0] r_count;

  logic [PTR_W-1:0] w_head1;
  logic [PTR_W-1:0] w_tail1;
  buf_entry_t       w_ent0;
  buf_entry_t       w_ent1;
  logic             w_pair_ok;
  logic             w_valid0;
  logic             w_valid1;
  logic             w_wr_en;
  logic [1:0]       w_wr_num;
  logic [1:0]       w_avail;
  logic [1:0]       w_take_num;

  assign w_head1 = r_head + PTR_W'(1);
  assign w_tail1 = r_tail + PTR_W'(1);
  assign w_ent0  = r_mem[r_head];
  assign w_ent1  = r_mem[w_head1];

  inst_pair_check u_pair_check (
    .i_slot0_inst (w_ent0.inst),
    .i_slot1_inst (w_ent1.inst),
    .o_pair_ok    (w_pair_ok)
  );

  assign w_valid0 = (r_count >= CNT_W'(1));
  assign w_valid1 = (r_count >= CNT_W'(2)) && w_pair_ok;

  // Two free slots are required even for a single-instruction fetch, so the
  // producer never has to look at fetch_cnt to know whether it will be taken.
  assign fetch_ready = (r_count <= READY_MAX);
  assign w_wr_en     = fetch_valid && fetch_ready;
  assign w_wr_num    = w_wr_en ? (fetch_cnt ? 2'd2 : 2'd1) : 2'd0;

  assign w_avail    = {1'b0, w_valid0} + {1'b0, w_valid1};
  assign w_take_num = (issue_take > w_avail) ? w_avail : issue_take;

  // NOTE: the storage array has no reset; validity is carried entirely by
  // r_count, so clearing it would only cost reset fan-out for no behaviour.
  always_ff @(posedge clk) begin
    if (w_wr_en) begin
      r_mem[r_tail] <= {fetch_pc, fetch_inst0};
      if (fetch_cnt) begin
        r_mem[w_tail1] <= {fetch_pc + 32'd4, fetch_inst1};
      end
    end
  end

  // NOTE: state registers use non-blocking assignments so every pointer and
  // the count update from the same pre-edge values.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_head  <= '0;
      r_tail  <= '0;
      r_count <= '0;
    end else if (flush) begin
      r_head  <= '0;
      r_tail  <= '0;
      r_count <= '0;
    end else begin
      r_head  <= r_head + PTR_W'(w_take_num);
      r_tail  <= r_tail + PTR_W'(w_wr_num);
      r_count <= r_count + CNT_W'(w_wr_num) - CNT_W'(w_take_num);
    end
  end

  assign issue_valid0 = w_valid0;
  assign issue_valid1 = w_valid1;
  assign issue_inst0  = w_valid0 ? w_ent0.inst : 32'd0;
  assign issue_pc0    = w_valid0 ? w_ent0.pc   : 32'd0;
  assign issue_inst1  = w_valid1 ? w_ent1.inst : 32'd0;
  assign issue_pc1    = w_valid1 ? w_ent1.pc   : 32'd0;
  assign occupancy    = r_count;

endmodule

// File: tb/tb_inst_issue_buffer.sv
// Directed bench for inst_issue_buffer with a queue-based reference model of
// the buffer contents and dual-issue pairing rules.
`timescale 1ns/1ps
module tb_inst_issue_buffer;

  logic        clk = 1'b0;
  logic        rst;
  logic        fetch_valid;
  logic        fetch_cnt;
  logic [31:0] fetch_pc;
  logic [31:0] fetch_inst0;
  logic [31:0] fetch_inst1;
  logic        fetch_ready;
  logic        issue_valid0;
  logic        issue_valid1;
  logic [31:0] issue_inst0;
  logic [31:0] issue_inst1;
  logic [31:0] issue_pc0;
  logic [31:0] issue_pc1;
  logic [1:0]  issue_take;
  logic        flush;
  logic [3:0]  occupancy;

  typedef struct {
    logic [31:0] pc;
    logic [31:0] inst;
  } ent_t;

  ent_t q[$];
  int   vectors     = 0;
  int   miscompares = 0;

  always #5 clk = ~clk;

  inst_issue_buffer dut (
    .clk          (clk),
    .rst          (rst),
    .fetch_valid  (fetch_valid),
    .fetch_cnt    (fetch_cnt),
    .fetch_pc     (fetch_pc),
    .fetch_inst0  (fetch_inst0),
    .fetch_inst1  (fetch_inst1),
    .fetch_ready  (fetch_ready),
    .issue_valid0 (issue_valid0),
    .issue_valid1 (issue_valid1),
    .issue_inst0  (issue_inst0),
    .issue_inst1  (issue_inst1),
    .issue_pc0    (issue_pc0),
    .issue_pc1    (issue_pc1),
    .issue_take   (issue_take),
    .flush        (flush),
    .occupancy    (occupancy)
  );

  function automatic logic [31:0] addi(input int rd, input int rs1, input int imm);
    logic [11:0] i12;
    logic [4:0]  d;
    logic [4:0]  s;
    i12 = 12'(imm);
    d   = 5'(rd);
    s   = 5'(rs1);
    return {i12, s, 3'b000, d, 7'h13};
  endfunction

  function automatic logic [31:0] add_r(input int rd, input int rs1, input int rs2);
    logic [4:0] d;
    logic [4:0] s1;
    logic [4:0] s2;
    d  = 5'(rd);
    s1 = 5'(rs1);
    s2 = 5'(rs2);
    return {7'b0, s2, s1, 3'b000, d, 7'h33};
  endfunction

  // Reference pairing rule, expressed by opcode class of each slot.
  function automatic logic model_pair_ok(input logic [31:0] a, input logic [31:0] b);
    logic [6:0] oa;
    logic [6:0] ob;
    logic       wr;
    logic       r1;
    logic       r2;
    oa = a[6:0];
    ob = b[6:0];
    if (oa inside {7'h63, 7'h6f, 7'h67}) return 1'b0;
    wr = oa inside {7'h33, 7'h13, 7'h03, 7'h17, 7'h37};
    r1 = ob inside {7'h33, 7'h13, 7'h03, 7'h23, 7'h63, 7'h67};
    r2 = ob inside {7'h33, 7'h23, 7'h63};
    if (!wr || a[11:7] == 5'd0) return 1'b1;
    return !((r1 && b[19:15] == a[11:7]) || (r2 && b[24:20] == a[11:7]));
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic check_state(input string tag);
    int          n;
    logic        ev0;
    logic        ev1;
    logic [31:0] epc0;
    logic [31:0] einst0;
    logic [31:0] epc1;
    logic [31:0] einst1;
    n      = q.size();
    ev0    = (n >= 1);
    ev1    = 1'b0;
    epc0   = 32'd0;
    einst0 = 32'd0;
    epc1   = 32'd0;
    einst1 = 32'd0;
    if (n >= 1) begin
      epc0   = q[0].pc;
      einst0 = q[0].inst;
    end
    if (n >= 2) ev1 = model_pair_ok(q[0].inst, q[1].inst);
    if (ev1) begin
      epc1   = q[1].pc;
      einst1 = q[1].inst;
    end
    check({tag, ".occupancy"}, 32'(occupancy), 32'(n));
    check({tag, ".fetch_ready"}, 32'(fetch_ready), 32'(n <= 6));
    check({tag, ".valid0"}, 32'(issue_valid0), 32'(ev0));
    check({tag, ".valid1"}, 32'(issue_valid1), 32'(ev1));
    check({tag, ".pc0"}, issue_pc0, epc0);
    check({tag, ".inst0"}, issue_inst0, einst0);
    check({tag, ".pc1"}, issue_pc1, epc1);
    check({tag, ".inst1"}, issue_inst1, einst1);
  endtask

  // Checks the state left by the previous edge, applies one cycle of
  // stimulus and advances the scoreboard to match the coming edge.
  task automatic cycle(input string tag, input logic fv, input logic cnt,
                       input logic [31:0] pc, input logic [31:0] i0,
                       input logic [31:0] i1, input logic [1:0] take,
                       input logic fl);
    int   nvalid;
    int   tk;
    logic ready_exp;
    @(negedge clk);
    fetch_valid = fv;
    fetch_cnt   = cnt;
    fetch_pc    = pc;
    fetch_inst0 = i0;
    fetch_inst1 = i1;
    issue_take  = take;
    flush       = fl;
    check_state(tag);
    ready_exp = (q.size() <= 6);
    nvalid    = 0;
    if (q.size() >= 1) nvalid = 1;
    if (q.size() >= 2 && model_pair_ok(q[0].inst, q[1].inst)) nvalid = 2;
    tk = (int'(take) > nvalid) ? nvalid : int'(take);
    repeat (tk) void'(q.pop_front());
    if (fv && ready_exp) begin
      q.push_back('{pc: pc, inst: i0});
      if (cnt) q.push_back('{pc: pc + 32'd4, inst: i1});
    end
    if (fl) q.delete();
    @(posedge clk);
  endtask

  task automatic idle(input string tag, input logic [1:0] take);
    cycle(tag, 1'b0, 1'b0, 32'd0, 32'd0, 32'd0, take, 1'b0);
  endtask

  initial begin
    rst         = 1'b1;
    fetch_valid = 1'b0;
    fetch_cnt   = 1'b0;
    fetch_pc    = 32'd0;
    fetch_inst0 = 32'd0;
    fetch_inst1 = 32'd0;
    issue_take  = 2'd0;
    flush       = 1'b0;
    #1;
    check_state("in_reset");
    repeat (2) @(negedge clk);
    rst = 1'b0;

    // Basic dual write, then both issue together.
    cycle("first_write", 1'b1, 1'b1, 32'h100, addi(1, 0, 1), addi(2, 0, 2), 2'd0, 1'b0);
    idle("pair_visible", 2'd2);

    // RAW dependency blocks slot 1; single take shifts it to slot 0.
    cycle("raw_write", 1'b1, 1'b1, 32'h200, addi(1, 0, 1), add_r(3, 1, 1), 2'd0, 1'b0);
    idle("raw_blocked", 2'd1);
    idle("raw_shift", 2'd1);

    // Fill to 7 with tail wrapping 7->0, then a rejected fetch while full.
    cycle("fill_a", 1'b1, 1'b1, 32'h300, addi(5, 0, 1), addi(6, 0, 2), 2'd0, 1'b0);
    cycle("fill_b", 1'b1, 1'b1, 32'h308, addi(5, 0, 3), addi(6, 0, 4), 2'd0, 1'b0);
    cycle("fill_c", 1'b1, 1'b1, 32'h310, addi(5, 0, 5), addi(6, 0, 6), 2'd0, 1'b0);
    cycle("fill_d", 1'b1, 1'b0, 32'h318, addi(5, 0, 7), 32'd0, 2'd0, 1'b0);
    cycle("full_reject", 1'b1, 1'b1, 32'h400, addi(9, 0, 9), addi(9, 0, 9), 2'd0, 1'b0);
    idle("full_take2", 2'd2);
    idle("drain_a", 2'd2);
    idle("drain_b", 2'd2);
    idle("drain_clamp", 2'd2);

    // Flush dominates a concurrent write and take.
    cycle("flush_pre_a", 1'b1, 1'b1, 32'h500, addi(5, 0, 1), addi(6, 0, 2), 2'd0, 1'b0);
    cycle("flush_pre_b", 1'b1, 1'b1, 32'h508, addi(7, 0, 3), addi(8, 0, 4), 2'd0, 1'b0);
    cycle("flush_hit", 1'b1, 1'b1, 32'h510, addi(5, 0, 5), addi(6, 0, 6), 2'd2, 1'b1);

    // Branch in slot 0 never pairs; take=2 removes only the branch.
    cycle("branch_write", 1'b1, 1'b1, 32'h600, 32'h0000_0463, addi(7, 0, 1), 2'd0, 1'b0);
    idle("branch_take2", 2'd2);
    cycle("after_branch", 1'b1, 1'b1, 32'h700, addi(8, 0, 1), addi(9, 8, 1), 2'd0, 1'b0);
    cycle("to_five", 1'b1, 1'b1, 32'h708, addi(10, 0, 1), addi(11, 0, 2), 2'd0, 1'b0);
    idle("occ_five", 2'd0);

    // Short asynchronous reset pulse between edges.
    #1 rst = 1'b1;
    q.delete();
    #1 check_state("rst_pulse");
    #2 rst = 1'b0;

    cycle("post_rst_write", 1'b1, 1'b0, 32'h800, addi(12, 0, 1), 32'd0, 2'd0, 1'b0);
    idle("post_rst_visible", 2'd1);
    idle("final_empty", 2'd0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
